// File: rtl/io_cpx_req_ctl.sv
// IO-side source stage of the IO-to-CPX path: queues outbound CPX packets,
// tracks per-destination CPX queue credits and issues one packet per cycle
// as a registered one-hot request followed one cycle later by its data.
module io_cpx_req_ctl #(
    parameter int DW    = 145,
    parameter int DEPTH = 4,
    parameter int NDEST = 8,
    parameter int CRED  = 2
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic             io_pkt_vld,
    input  logic [NDEST-1:0] io_pkt_dest,
    input  logic [DW-1:0]    io_pkt_data,
    output logic             io_pkt_rdy,
    input  logic [NDEST-1:0] cpx_io_grant_ca,
    output logic [NDEST-1:0] io_cpx_req_cq,
    output logic [DW-1:0]    io_cpx_data_ca,
    output logic             io_cpx_err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(CRED + 1);

    logic [DW-1:0]    data_mem_q [DEPTH];
    logic [NDEST-1:0] dest_mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [CW-1:0]    cred_q [NDEST];
    logic [CW-1:0]    cred_d [NDEST];
    logic [NDEST-1:0] req_q, req_d;
    logic [DW-1:0]    iss_data_q, iss_data_d;
    logic [DW-1:0]    data_q, data_d;
    logic             err_q, err_d;

    logic             dest_ok;
    logic             push;
    logic             push_ok;
    logic             issue;
    logic             head_cred;
    logic             sat_err;
    logic [NDEST-1:0] head_dest;
    logic [DW-1:0]    head_data;

    assign io_pkt_rdy     = (count_q < CNTW'(DEPTH));
    assign io_cpx_req_cq  = req_q;
    assign io_cpx_data_ca = data_q;
    assign io_cpx_err     = err_q;

    // Accept, issue, credit and error next-state logic.
    always_comb begin
        dest_ok   = (io_pkt_dest != '0) &&
                    ((io_pkt_dest & (io_pkt_dest - NDEST'(1))) == '0);
        push      = io_pkt_vld && io_pkt_rdy;
        push_ok   = push && dest_ok;
        head_dest = dest_mem_q[rd_ptr_q];
        head_data = data_mem_q[rd_ptr_q];

        head_cred = 1'b0;
        for (int unsigned i = 0; i < NDEST; i++) begin
            if (head_dest[i] && (cred_q[i] != '0)) begin
                head_cred = 1'b1;
            end
        end
        issue = (count_q != '0) && head_cred;

        // A grant landing in the same cycle as an issue to that destination
        // cancels out; only an unmatched grant on a full counter is an error.
        sat_err = 1'b0;
        for (int unsigned i = 0; i < NDEST; i++) begin
            cred_d[i] = cred_q[i];
            if (cpx_io_grant_ca[i] && !(issue && head_dest[i])) begin
                if (cred_q[i] == CW'(CRED)) begin
                    sat_err = 1'b1;
                end else begin
                    cred_d[i] = cred_q[i] + CW'(1);
                end
            end else if (!cpx_io_grant_ca[i] && issue && head_dest[i]) begin
                cred_d[i] = cred_q[i] - CW'(1);
            end
        end

        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(issue);
        count_d    = count_q + CNTW'(push_ok) - CNTW'(issue);
        req_d      = issue ? head_dest : '0;
        iss_data_d = issue ? head_data : '0;
        data_d     = iss_data_q;
        err_d      = err_q || (push && !dest_ok) || sat_err;
    end

    // Packet storage; contents are don't-care until written, so no reset.
    always_ff @(posedge rclk) begin
        if (push_ok) begin
            data_mem_q[wr_ptr_q] <= io_pkt_data;
            dest_mem_q[wr_ptr_q] <= io_pkt_dest;
        end
    end

    // Control state, credits and the request/data output pipeline.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < NDEST; i++) begin
                cred_q[i] <= CW'(CRED);
            end
            req_q      <= '0;
            iss_data_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cred_q     <= cred_d;
            req_q      <= req_d;
            iss_data_q <= iss_data_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_io_cpx_req_ctl.sv
// Directed bench for io_cpx_req_ctl with an in-order request/data scoreboard.
module tb_io_cpx_req_ctl;

    localparam int DW    = 145;
    localparam int DEPTH = 4;
    localparam int NDEST = 8;
    localparam int CRED  = 2;

    typedef struct packed {
        logic [NDEST-1:0] dest;
        logic [DW-1:0]    data;
    } ent_t;

    logic             clk = 1'b0;
    logic             arst_l = 1'b0;
    logic             io_pkt_vld = 1'b0;
    logic [NDEST-1:0] io_pkt_dest = '0;
    logic [DW-1:0]    io_pkt_data = '0;
    logic             io_pkt_rdy;
    logic [NDEST-1:0] cpx_io_grant_ca = '0;
    logic [NDEST-1:0] io_cpx_req_cq;
    logic [DW-1:0]    io_cpx_data_ca;
    logic             io_cpx_err;

    int n_chk  = 0;
    int n_fail = 0;
    ent_t sb[$];
    logic          data_due = 1'b0;
    logic [DW-1:0] exp_data = '0;
    int unsigned   seq = 1;

    io_cpx_req_ctl #(.DW(DW), .DEPTH(DEPTH), .NDEST(NDEST), .CRED(CRED)) dut (
        .rclk            (clk),
        .arst_l          (arst_l),
        .io_pkt_vld      (io_pkt_vld),
        .io_pkt_dest     (io_pkt_dest),
        .io_pkt_data     (io_pkt_data),
        .io_pkt_rdy      (io_pkt_rdy),
        .cpx_io_grant_ca (cpx_io_grant_ca),
        .io_cpx_req_cq   (io_cpx_req_cq),
        .io_cpx_data_ca  (io_cpx_data_ca),
        .io_cpx_err      (io_cpx_err)
    );

    always #5 clk = ~clk;

    task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [NDEST-1:0] obs, input logic [NDEST-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int unsigned n);
        logic [159:0] t;
        t = {n, ~n, n ^ 32'hA5A5_5A5A, n + 32'd7, 32'hC0DE_0000 | n};
        return t[DW-1:0];
    endfunction

    // One cycle: drive after the rising edge, return at the falling edge.
    task automatic step(input logic v, input logic [NDEST-1:0] d,
                        input logic [DW-1:0] dat, input logic [NDEST-1:0] g);
        @(posedge clk);
        #1;
        io_pkt_vld      = v;
        io_pkt_dest     = d;
        io_pkt_data     = dat;
        cpx_io_grant_ca = g;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
    endtask

    // Push a packet expected to be accepted this cycle and record it.
    task automatic push(input logic [NDEST-1:0] d, input logic [NDEST-1:0] g);
        logic [DW-1:0] dat;
        dat = mkdata(seq);
        seq++;
        step(1'b1, d, dat, g);
        chk_b("push_rdy", io_pkt_rdy, 1'b1);
        sb.push_back('{dest: d, data: dat});
    endtask

    task automatic do_reset();
        arst_l          = 1'b0;
        io_pkt_vld      = 1'b0;
        io_pkt_dest     = '0;
        io_pkt_data     = '0;
        cpx_io_grant_ca = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 arst_l = 1'b1;
        @(negedge clk);
        chk_v("rst_req", io_cpx_req_cq, '0);
        chk_d("rst_data", io_cpx_data_ca, '0);
        chk_b("rst_err", io_cpx_err, 1'b0);
        chk_b("rst_rdy", io_pkt_rdy, 1'b1);
    endtask

    // Scoreboard: every request must match the oldest outstanding packet and
    // its data must follow exactly one cycle later; otherwise data is zero.
    always @(negedge clk) begin
        if (!arst_l) begin
            data_due = 1'b0;
        end else begin
            if (data_due) chk_d("mon_data", io_cpx_data_ca, exp_data);
            else          chk_d("mon_data_zero", io_cpx_data_ca, '0);
            data_due = 1'b0;
            if (io_cpx_req_cq != '0) begin
                chk_b("mon_req_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    ent_t e;
                    e = sb.pop_front();
                    chk_v("mon_req_dest", io_cpx_req_cq, e.dest);
                    exp_data = e.data;
                    data_due = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] p4;

        do_reset();

        // Single packet latency: request in cycle 2 only, data in cycle 3 only.
        a = mkdata(32'h0000_A000);
        step(1'b1, 8'h04, a, '0);
        sb.push_back('{dest: 8'h04, data: a});
        chk_v("t1_req_c0", io_cpx_req_cq, '0);
        idle(1); chk_v("t1_req_c1", io_cpx_req_cq, '0);
        idle(1); chk_v("t1_req_c2", io_cpx_req_cq, 8'h04);
                 chk_d("t1_data_c2", io_cpx_data_ca, '0);
        idle(1); chk_v("t1_req_c3", io_cpx_req_cq, '0);
                 chk_d("t1_data_c3", io_cpx_data_ca, a);
        idle(1); chk_d("t1_data_c4", io_cpx_data_ca, '0);
        chk_b("t1_sb_empty", sb.size() == 0, 1'b1);

        // Two credits: two back-to-back requests, third waits for a grant.
        push(8'h01, '0);
        push(8'h01, '0);
        push(8'h01, '0); chk_v("t2_req_k2", io_cpx_req_cq, 8'h01);
        idle(1);         chk_v("t2_req_k3", io_cpx_req_cq, 8'h01);
        for (int i = 0; i < 3; i++) begin
            idle(1); chk_v("t2_req_held", io_cpx_req_cq, '0);
        end
        step(1'b0, '0, '0, 8'h01); chk_v("t2_req_gnt", io_cpx_req_cq, '0);
        idle(1); chk_v("t2_req_gnt1", io_cpx_req_cq, '0);
        idle(1); chk_v("t2_req_gnt2", io_cpx_req_cq, 8'h01);
        idle(2);
        chk_b("t2_sb_empty", sb.size() == 0, 1'b1);

        // Fill the FIFO behind a zero-credit head; the fifth packet waits.
        for (int i = 0; i < DEPTH; i++) push(8'h01, '0);
        p4 = mkdata(seq);
        seq++;
        step(1'b1, 8'h01, p4, '0);     chk_b("t3_full_k4", io_pkt_rdy, 1'b0);
        step(1'b1, 8'h01, p4, '0);     chk_b("t3_full_k5", io_pkt_rdy, 1'b0);
        step(1'b1, 8'h01, p4, 8'h01);  chk_b("t3_full_k6", io_pkt_rdy, 1'b0);
        step(1'b1, 8'h01, p4, '0);     chk_b("t3_full_pop", io_pkt_rdy, 1'b0);
        step(1'b1, 8'h01, p4, '0);     chk_b("t3_rdy_again", io_pkt_rdy, 1'b1);
        chk_v("t3_req_k8", io_cpx_req_cq, 8'h01);
        sb.push_back('{dest: 8'h01, data: p4});
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 8'h01);
        idle(6);
        chk_b("t3_sb_empty", sb.size() == 0, 1'b1);

        // Head-of-line blocking: 0x10 has credit but sits behind a blocked 0x02.
        push(8'h02, '0);
        push(8'h02, '0);
        push(8'h02, '0); chk_v("t4_req_k2", io_cpx_req_cq, 8'h02);
        push(8'h10, '0); chk_v("t4_req_k3", io_cpx_req_cq, 8'h02);
        for (int i = 0; i < 5; i++) begin
            idle(1); chk_v("t4_hol", io_cpx_req_cq, '0);
        end
        step(1'b0, '0, '0, 8'h02); chk_v("t4_req_gnt", io_cpx_req_cq, '0);
        idle(1); chk_v("t4_req_k10", io_cpx_req_cq, '0);
        idle(1); chk_v("t4_req_k11", io_cpx_req_cq, 8'h02);
        idle(1); chk_v("t4_req_k12", io_cpx_req_cq, 8'h10);
        idle(3);
        chk_b("t4_sb_empty", sb.size() == 0, 1'b1);

        // Issue and grant to 0x08 in the same cycle at credit 1: stays at 1.
        push(8'h08, '0);
        push(8'h08, '0);
        step(1'b0, '0, '0, 8'h08); chk_v("t5_req_k2", io_cpx_req_cq, 8'h08);
        idle(1); chk_v("t5_req_k3", io_cpx_req_cq, 8'h08);
        idle(2);
        push(8'h08, '0);
        push(8'h08, '0);
        idle(1); chk_v("t5_req_k8", io_cpx_req_cq, 8'h08);
        for (int i = 0; i < 4; i++) begin
            idle(1); chk_v("t5_one_credit", io_cpx_req_cq, '0);
        end
        step(1'b0, '0, '0, 8'h08); chk_v("t5_req_k13", io_cpx_req_cq, '0);
        idle(1); chk_v("t5_req_k14", io_cpx_req_cq, '0);
        idle(1); chk_v("t5_req_k15", io_cpx_req_cq, 8'h08);
        idle(3);
        chk_b("t5_sb_empty", sb.size() == 0, 1'b1);
        chk_b("t5_err_clear", io_cpx_err, 1'b0);

        // Grant to a destination already at full credit sets the sticky error.
        step(1'b0, '0, '0, 8'h80); chk_b("t5_err_gnt_cyc", io_cpx_err, 1'b0);
        idle(1); chk_b("t5_err_set", io_cpx_err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1); chk_b("t5_err_sticky", io_cpx_err, 1'b1);
        end

        // Multi-hot destination is dropped and flags an error.
        do_reset();
        step(1'b1, 8'h03, mkdata(32'h0000_0333), '0);
        chk_b("t6_err_pre", io_cpx_err, 1'b0);
        chk_b("t6_rdy", io_pkt_rdy, 1'b1);
        idle(1); chk_b("t6_err_set", io_cpx_err, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle(1); chk_v("t6_no_req", io_cpx_req_cq, '0);
        end
        chk_b("t6_rdy_after", io_pkt_rdy, 1'b1);

        // Reset mid-stream with three packets queued and one in flight.
        do_reset();
        for (int i = 0; i < 6; i++) push(8'h40, '0);
        step(1'b0, '0, '0, 8'h40);
        idle(1);
        idle(1); chk_v("t7_req_before_rst", io_cpx_req_cq, 8'h40);
        #1;
        arst_l = 1'b0;
        sb.delete();
        #1;
        chk_v("t7_rst_req", io_cpx_req_cq, '0);
        chk_d("t7_rst_data", io_cpx_data_ca, '0);
        chk_b("t7_rst_rdy", io_pkt_rdy, 1'b1);
        repeat (2) @(posedge clk);
        #1 arst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk_v("t7_discard_req", io_cpx_req_cq, '0);
            chk_d("t7_discard_data", io_cpx_data_ca, '0);
        end
        push(8'h40, '0);
        push(8'h40, '0);
        push(8'h40, '0); chk_v("t7_cred_k2", io_cpx_req_cq, 8'h40);
        idle(1); chk_v("t7_cred_k3", io_cpx_req_cq, 8'h40);
        idle(1); chk_v("t7_cred_k4", io_cpx_req_cq, '0);
        idle(2);
        chk_b("t7_one_blocked", sb.size() == 1, 1'b1);
        chk_b("t7_err", io_cpx_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
